// File: rtl/flow_cpu_pkg.sv
// rtl/flow_cpu_pkg.sv - shared types and constants for the flow_cpu pipeline
// Contents: fetch_state_t (S_REQ/S_HOLD/S_DROP), NOP_INST, DEFAULT_RESET_PC.
package flow_cpu_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // request outstanding
    S_HOLD = 2'd1,  // fetched word parked in the hold buffer while ID stalls
    S_DROP = 2'd2   // stale response still in flight after a redirect
  } fetch_state_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - single-entry hold register for a fetched instruction word
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   load, data    capture data into the entry
//   clear         empty the entry (wins over load)
//   q, full       held word and occupancy flag
module fetch_buffer
  import flow_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] data,
  output logic [31:0] q,
  output logic        full
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= NOP_INST;
      full <= 1'b0;
    end else if (clear) begin
      q    <= NOP_INST;
      full <= 1'b0;
    end else if (load) begin
      q    <= data;
      full <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage driving the IF/ID register
// Optional feature macro: FETCH_PERF_CNT_EN (fetch/stall performance counters).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   stall                       ID cannot accept an instruction this cycle
//   redirect_valid, redirect_pc taken branch/jump target from ID
//   imem_req, imem_addr         single-outstanding instruction memory request
//   imem_rvalid, imem_rdata     instruction memory response
//   if_id_inst/pc4/valid        IF/ID pipeline register
//   perf_fetch_cnt/stall_cnt    performance counters (0 when feature disabled)
module fetch_stage
  import flow_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n, pc_plus4;
  logic         ifid_load, ifid_bubble, ifid_from_buf;
  logic         buf_load, buf_clear, buf_full;
  logic [31:0]  buf_q;
  logic         unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign pc_plus4 = pc + 32'd4;

  // Request and address come from registers only; rst just masks the request.
  assign imem_req  = (state == S_REQ) && !rst;
  assign imem_addr = pc;

  fetch_buffer u_fetch_buffer (
    .clk   (clk),
    .rst   (rst),
    .load  (buf_load),
    .clear (buf_clear),
    .data  (imem_rdata),
    .q     (buf_q),
    .full  (buf_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
      pc    <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    ifid_load     = 1'b0;
    ifid_bubble   = 1'b0;
    ifid_from_buf = 1'b0;
    buf_load      = 1'b0;
    buf_clear     = 1'b0;

    if (redirect_valid) begin
      ifid_bubble = 1'b1;
      buf_clear   = 1'b1;
      pc_n        = {redirect_pc[31:2], 2'b00};
      case (state)
        // With the request still in flight its response must be swallowed.
        S_REQ:   state_n = imem_rvalid ? S_REQ : S_DROP;
        S_HOLD:  state_n = S_REQ;
        S_DROP:  state_n = imem_rvalid ? S_REQ : S_DROP;
        default: state_n = S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (imem_rvalid && !stall) begin
            ifid_load = 1'b1;
            pc_n      = pc_plus4;
          end else if (imem_rvalid) begin
            buf_load = 1'b1;
            state_n  = S_HOLD;
          end else if (!stall) begin
            ifid_bubble = 1'b1;
          end
        end
        S_HOLD: begin
          if (!stall && buf_full) begin
            ifid_load     = 1'b1;
            ifid_from_buf = 1'b1;
            buf_clear     = 1'b1;
            pc_n          = pc_plus4;
            state_n       = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rvalid) state_n = S_REQ;
        end
        default: state_n = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || ifid_bubble) begin
      if_id_inst  <= NOP_INST;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
    end else if (ifid_load) begin
      if_id_inst  <= ifid_from_buf ? buf_q : imem_rdata;
      if_id_pc4   <= pc_plus4;
      if_id_valid <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (ifid_load)            fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall && if_id_valid) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  logic        zero_wait;
  logic        use_mem;
  logic        rvalid_drv;
  logic [31:0] rdata_drv;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2008_0001 + {2'b00, a[31:2]};
  endfunction

  assign imem_rvalid = zero_wait ? imem_req : rvalid_drv;
  assign imem_rdata  = use_mem ? mem_word(imem_addr) : rdata_drv;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_id_inst     (if_id_inst),
    .if_id_pc4      (if_id_pc4),
    .if_id_valid    (if_id_valid),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_cnt(input logic [31:0] n);
`ifdef FETCH_PERF_CNT_EN
    return n;
`else
    return 32'd0 & n;
`endif
  endfunction

  task automatic check_ifid(input string tag, input logic [31:0] inst,
                            input logic [31:0] pc4, input logic valid);
    check({tag, "_inst"},  if_id_inst, inst);
    check({tag, "_pc4"},   if_id_pc4, pc4);
    check({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, valid});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    zero_wait = 1'b0; use_mem = 1'b1; rvalid_drv = 1'b0; rdata_drv = 32'd0;

    // Reset state
    step(); step();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check_ifid("rst", 32'd0, 32'd0, 1'b0);
    check("rst_fcnt", perf_fetch_cnt, 32'd0);
    check("rst_scnt", perf_stall_cnt, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_req", {31'd0, imem_req}, 32'd1);
    check("post_rst_addr", imem_addr, 32'd0);

    // Zero-wait memory, three consecutive fetches
    zero_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_ifid($sformatf("zw%0d", i), 32'h2008_0001 + i, 32'd4 * (i + 1), 1'b1);
    end
    check("zw_fcnt", perf_fetch_cnt, exp_cnt(32'd3));
    zero_wait = 1'b0;

    // Two-cycle latency: valid pattern 0,0,1 with stable address
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 3; k++) begin
        rvalid_drv = (k == 2);
        check($sformatf("lat%0d_%0d_addr", n, k), imem_addr, 32'd12 + 32'd4 * n);
        step();
        check($sformatf("lat%0d_%0d_valid", n, k), {31'd0, if_id_valid}, {31'd0, k == 2});
      end
      check_ifid($sformatf("lat%0d", n), 32'h2008_0004 + n, 32'd16 + 32'd4 * n, 1'b1);
      rvalid_drv = 1'b0;
    end

    // Stall for three cycles while the response arrives
    use_mem = 1'b0; rdata_drv = 32'h8C02_0004; rvalid_drv = 1'b1; stall = 1'b1;
    step();
    rvalid_drv = 1'b0;
    check("hold_req", {31'd0, imem_req}, 32'd0);
    step(); step();
    check_ifid("hold", 32'h2008_0005, 32'd20, 1'b1);
    stall = 1'b0;
    step();
    check_ifid("release", 32'h8C02_0004, 32'd24, 1'b1);
    check("release_scnt", perf_stall_cnt, exp_cnt(32'd3));
    check("release_fcnt", perf_fetch_cnt, exp_cnt(32'd6));
    check("release_addr", imem_addr, 32'd24);
    step();
    check("no_dup_valid", {31'd0, if_id_valid}, 32'd0);

    // Redirect with zero-wait memory
    use_mem = 1'b1; zero_wait = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    check("redir_addr", imem_addr, 32'h100);
    check("redir_bubble", {31'd0, if_id_valid}, 32'd0);
    step();
    check_ifid("redir_tgt", 32'h2008_0041, 32'h104, 1'b1);
    zero_wait = 1'b0;

    // Redirect while a slow request is outstanding
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    check("drop_req", {31'd0, imem_req}, 32'd0);
    check("drop_addr", imem_addr, 32'h200);
    step();
    use_mem = 1'b0; rdata_drv = 32'hDEAD_BEEF; rvalid_drv = 1'b1;
    step();
    rvalid_drv = 1'b0;
    check("drop_discard_valid", {31'd0, if_id_valid}, 32'd0);
    check("drop_exit_req", {31'd0, imem_req}, 32'd1);
    use_mem = 1'b1; zero_wait = 1'b1;
    step();
    check_ifid("drop_tgt", 32'h2008_0081, 32'h204, 1'b1);
    check("drop_fcnt", perf_fetch_cnt, exp_cnt(32'd8));
    zero_wait = 1'b0;

    // Reset while holding a buffered word
    use_mem = 1'b0; rdata_drv = 32'h1111_1111; rvalid_drv = 1'b1; stall = 1'b1;
    step();
    rvalid_drv = 1'b0;
    check("rh_hold_req", {31'd0, imem_req}, 32'd0);
    check("rh_scnt", perf_stall_cnt, exp_cnt(32'd4));
    rst = 1'b1;
    step();
    check("rh_req", {31'd0, imem_req}, 32'd0);
    check_ifid("rh", 32'd0, 32'd0, 1'b0);
    check("rh_fcnt", perf_fetch_cnt, 32'd0);
    check("rh_scnt0", perf_stall_cnt, 32'd0);
    rst = 1'b0; stall = 1'b0;
    #1;
    check("rh_addr", imem_addr, 32'd0);
    check("rh_req1", {31'd0, imem_req}, 32'd1);
    step();
    check("rh_buf_empty", {31'd0, if_id_valid}, 32'd0);
    use_mem = 1'b1; zero_wait = 1'b1;
    step();
    check_ifid("rh_refetch", 32'h2008_0001, 32'd4, 1'b1);
    check("rh_refetch_fcnt", perf_fetch_cnt, exp_cnt(32'd1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
